// File: rtl/alu_pkg.sv
// Shared definitions for the ALU self-test slice: opcode values, default sweep
// width and the sweep controller state type.
package alu_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;

  localparam int unsigned NUM_OPS_DEF = 5;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_CHECK,
    ST_DONE
  } state_t;

endpackage

// File: rtl/alu_ref_model.sv
// Golden 4-bit ALU: combinational {carry, result} expected for one vector.
module alu_ref_model
  import alu_pkg::*;
(
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic [2:0] alu_sel,
  output logic [4:0] expected
);

  always_comb begin
    expected = '0;
    unique case (alu_sel)
      OP_ADD:  expected = {1'b0, a} + {1'b0, b};
      // Mod-32 subtraction leaves the borrow in bit 4.
      OP_SUB:  expected = {1'b0, a} - {1'b0, b};
      OP_AND:  expected = {1'b0, a & b};
      OP_OR:   expected = {1'b0, a | b};
      OP_XOR:  expected = {1'b0, a ^ b};
      default: expected = '0;
    endcase
  end

endmodule

// File: rtl/alu_sweep_checker.sv
// Exhaustive ALU sweep engine: drives every a/b/opcode vector, compares the
// ALU response with alu_ref_model, counts pass/fail and records the first fail.
module alu_sweep_checker
  import alu_pkg::*;
#(
  parameter int unsigned SETTLE  = 1,
  parameter int unsigned NUM_OPS = NUM_OPS_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic [3:0]  a,
  output logic [3:0]  b,
  output logic [2:0]  alu_sel,
  input  logic [3:0]  alu_out,
  input  logic        carry_out,
  output logic        busy,
  output logic        done,
  output logic [10:0] pass_count,
  output logic [10:0] fail_count,
  output logic        fail_valid,
  output logic [3:0]  fail_a,
  output logic [3:0]  fail_b,
  output logic [2:0]  fail_sel,
  output logic [4:0]  fail_got,
  output logic [4:0]  fail_exp
);

  localparam int unsigned      SW          = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [SW-1:0]    SETTLE_LAST = SW'(SETTLE - 1);
  localparam logic [2:0]       LAST_SEL    = 3'(NUM_OPS - 1);

  state_t        state_q, state_d;
  logic [SW-1:0] settle_q, settle_d;
  logic [3:0]    a_q, a_d, b_q, b_d;
  logic [2:0]    sel_q, sel_d;
  logic [10:0]   pass_q, pass_d, fail_q, fail_d;
  logic          fv_q, fv_d, busy_q, busy_d, done_q, done_d;
  logic [3:0]    fa_q, fa_d, fb_q, fb_d;
  logic [2:0]    fs_q, fs_d;
  logic [4:0]    fg_q, fg_d, fe_q, fe_d;
  logic [4:0]    expected;
  logic          last_vec;

  alu_ref_model u_ref (
    .a        (a_q),
    .b        (b_q),
    .alu_sel  (sel_q),
    .expected (expected)
  );

  assign last_vec = (a_q == 4'hF) && (b_q == 4'hF) && (sel_q == LAST_SEL);

  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    a_d      = a_q;
    b_d      = b_q;
    sel_d    = sel_q;
    pass_d   = pass_q;
    fail_d   = fail_q;
    fv_d     = fv_q;
    fa_d     = fa_q;
    fb_d     = fb_q;
    fs_d     = fs_q;
    fg_d     = fg_q;
    fe_d     = fe_q;
    busy_d   = busy_q;
    done_d   = done_q;

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        // done/busy settle one edge after entering DONE, matching the
        // registered-output timing of the sweep.
        if (state_q == ST_DONE) begin
          done_d = 1'b1;
          busy_d = 1'b0;
        end
        if (start) begin
          state_d  = ST_DRIVE;
          settle_d = '0;
          a_d      = '0;
          b_d      = '0;
          sel_d    = '0;
          pass_d   = '0;
          fail_d   = '0;
          fv_d     = 1'b0;
          fa_d     = '0;
          fb_d     = '0;
          fs_d     = '0;
          fg_d     = '0;
          fe_d     = '0;
          busy_d   = 1'b1;
          done_d   = 1'b0;
        end
      end

      ST_DRIVE: begin
        if (settle_q == SETTLE_LAST) begin
          state_d  = ST_CHECK;
          settle_d = '0;
        end else begin
          settle_d = settle_q + SW'(1);
        end
      end

      ST_CHECK: begin
        // X/Z on the ALU response makes the equality non-true, so it lands
        // in the fail branch.
        if ({carry_out, alu_out} == expected) begin
          pass_d = pass_q + 11'd1;
        end else begin
          fail_d = fail_q + 11'd1;
          if (!fv_q) begin
            fv_d = 1'b1;
            fa_d = a_q;
            fb_d = b_q;
            fs_d = sel_q;
            fg_d = {carry_out, alu_out};
            fe_d = expected;
          end
        end
        if (last_vec) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_DRIVE;
          if (sel_q == LAST_SEL) begin
            sel_d = '0;
            if (b_q == 4'hF) begin
              b_d = '0;
              a_d = a_q + 4'd1;
            end else begin
              b_d = b_q + 4'd1;
            end
          end else begin
            sel_d = sel_q + 3'd1;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      settle_q <= '0;
      a_q      <= '0;
      b_q      <= '0;
      sel_q    <= '0;
      pass_q   <= '0;
      fail_q   <= '0;
      fv_q     <= 1'b0;
      fa_q     <= '0;
      fb_q     <= '0;
      fs_q     <= '0;
      fg_q     <= '0;
      fe_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
      a_q      <= a_d;
      b_q      <= b_d;
      sel_q    <= sel_d;
      pass_q   <= pass_d;
      fail_q   <= fail_d;
      fv_q     <= fv_d;
      fa_q     <= fa_d;
      fb_q     <= fb_d;
      fs_q     <= fs_d;
      fg_q     <= fg_d;
      fe_q     <= fe_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign a          = a_q;
  assign b          = b_q;
  assign alu_sel    = sel_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass_count = pass_q;
  assign fail_count = fail_q;
  assign fail_valid = fv_q;
  assign fail_a     = fa_q;
  assign fail_b     = fb_q;
  assign fail_sel   = fs_q;
  assign fail_got   = fg_q;
  assign fail_exp   = fe_q;

endmodule

// File: doc/alu_sweep_checker.md
# alu_sweep_checker

Self-checking stimulus engine for the 4-bit ALU. On `start` it drives every operand/opcode combination into the ALU (16 × 16 × 5 = 1280 vectors), samples `{carry_out, alu_out}` and compares it against an internal reference model. It keeps pass/fail counts and captures the first mismatch. It is the driving end of the ALU operand/result interface and is used for on-silicon or FPGA self-test of the ALU.

## Interface
Parameters:
- `SETTLE`, 1 — cycles operands are held before the result is sampled (≥1).
- `NUM_OPS`, 5 — opcodes swept: 0 to NUM_OPS-1.

Ports:
- `clk`  in  1  — single clock.
- `rst_n`  in  1  — asynchronous, active-low reset.
- `start`  in  1  — one-cycle request to begin a sweep.
- `a`  out  4  — ALU operand A (registered).
- `b`  out  4  — ALU operand B (registered).
- `alu_sel`  out  3  — ALU opcode (registered).
- `alu_out`  in  4  — ALU result.
- `carry_out`  in  1  — ALU carry/borrow.
- `busy`  out  1  — sweep in progress.
- `done`  out  1  — sweep complete; level, held until the next accepted `start`.
- `pass_count`  out  11  — vectors matched.
- `fail_count`  out  11  — vectors mismatched.
- `fail_valid`  out  1  — first-fail record is valid.
- `fail_a`, `fail_b`  out  4 each  — operands of the first failure.
- `fail_sel`  out  3  — opcode of the first failure.
- `fail_got`, `fail_exp`  out  5 each  — observed and expected `{carry, result}` of the first failure.

## Operation
- States:
  - IDLE: `start` → DRIVE, with all counters, `done`, `fail_*` and the vector index cleared.
  - DRIVE: hold for SETTLE cycles → CHECK.
  - CHECK: compare, update one counter, then advance. On the last vector go to DONE, otherwise return to DRIVE.
  - DONE: `start` restarts exactly as from IDLE.
- `start` in DRIVE or CHECK is ignored.
- Sweep order: `a` is the outermost loop, `b` the middle, `alu_sel` the innermost (fastest). Each runs from 0 upward.
- Expected value, 5 bits:
  - 000: `a + b` zero-extended.
  - 001: `a - b` modulo 32, so bit 4 is the borrow (0 − 1 = 5'b11111).
  - 010: `{0, a & b}`.
  - 011: `{0, a | b}`.
  - 100: `{0, a ^ b}`.
  - Others: 5'b00000.
- Compare uses full 5-bit equality. Any X/Z on the inputs counts as a fail.
- First mismatch only: latch `fail_a`, `fail_b`, `fail_sel`, `fail_got`, `fail_exp` and set `fail_valid`. Later fails only increment `fail_count`.
- `pass_count + fail_count` = 1280 at DONE (NUM_OPS=5). Counters cannot overflow (max 1280 < 2048).

## Timing
- Reset (async assert, sync-safe deassert): state IDLE; `a`, `b`, `alu_sel` = 0; `busy` = 0; `done` = 0; counters = 0; `fail_valid` = 0 and all `fail_*` = 0.
- `start` sampled high in IDLE/DONE: `busy` = 1 and the first vector is on `a`/`b`/`alu_sel` the next cycle.
- Per vector: SETTLE cycles in DRIVE plus 1 in CHECK. The result is sampled on the CHECK cycle. Operands change only on leaving CHECK.
- Full sweep: 1280 × (SETTLE+1) cycles. With SETTLE=1, `done` rises 2561 cycles after the `start` edge.
- Counters and the fail record update on the clock edge ending CHECK. `done` and `busy`↓ occur together on the edge after the last CHECK.
- Operands hold their last vector (a=15, b=15, sel=4) in DONE.
- Reset mid-sweep: immediate return to reset values. The sweep does not resume.

## Structure
- Package `alu_pkg`: opcode constants (ADD=000, SUB=001, AND=010, OR=011, XOR=100), NUM_OPS default, state encoding.
- Sub-module `alu_ref_model`: combinational, inputs `a`/`b`/`alu_sel`, output 5-bit expected value. It is reused by the testbench scoreboard.
- Top: FSM, SETTLE counter, 11-bit vector index decoded to a/b/sel (or three nested counters), counters, first-fail register.

## Test plan
- Correct ALU, SETTLE=1, `start` pulse → `done` at cycle 2561; pass=1280, fail=0, `fail_valid`=0.
- ALU with `carry_out` stuck at 0 → pass=1040, fail=240 (120 add carries + 120 sub borrows). First fail: a=0, b=1, sel=001, got=5'b01111, exp=5'b11111.
- `start` re-pulsed at cycle 100 and again in mid-sweep → ignored; counts and `done` timing are unchanged.
- `rst_n` low at cycle 1000 → all outputs at reset values asynchronously. A new `start` gives a full clean sweep with pass=1280.
- After `done`, a second `start` → `done`/`fail_valid` clear and counters restart from 0. SETTLE=3 → `done` at cycle 1280×4+1.
